// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared types and constants for the mul/div sequencer
package muldiv_sequencer_pkg;

  localparam int DATA_W = 32;

  // X-stage decode of the two instructions that use the iterative unit
  localparam logic [4:0] OPC_ALU   = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_seq_counter.sv
// rtl/muldiv_sequencer_seq_counter.sv - busy-cycle counter with terminal count at TIMEOUT-1
module seq_counter #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear has priority over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - issues and tracks one mul/div on the shared iterative unit
module muldiv_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              is_mul,
  input  logic              is_div,
  input  logic [DATA_W-1:0] data_A,
  input  logic [DATA_W-1:0] data_B,
  input  logic              x_advance,
  input  logic              flush,
  input  logic              unit_ready,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exception,
  output logic              ctrl_mult,
  output logic              ctrl_div,
  output logic [DATA_W-1:0] unit_A,
  output logic [DATA_W-1:0] unit_B,
  output logic              muldiv_ready,
  output logic [DATA_W-1:0] muldiv_res,
  output logic              muldivov,
  output logic              busy
);
  import muldiv_sequencer_pkg::*;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ov_q, ov_d, ready_q, ready_d;
  logic              ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
  logic              accept, div_by_zero, cnt_tc;

  // mul wins when both decode bits are set, so only a pure div can divide by zero
  assign accept      = (state_q == S_IDLE) && (is_mul || is_div) && !flush;
  assign div_by_zero = is_div && !is_mul && (data_B == '0);

  seq_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_seq_counter (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (state_q == S_BUSY),
    .tc    (cnt_tc)
  );

  // next-state and registered-output logic; flush overrides everything else
  always_comb begin
    state_d     = state_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    res_d       = res_q;
    ov_d        = ov_q;
    ready_d     = ready_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      ready_d = 1'b0;
      res_d   = '0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul || is_div) begin
            unit_a_d = data_A;
            unit_b_d = data_B;
            if (div_by_zero) begin
              state_d = S_DONE;
              ready_d = 1'b1;
              res_d   = '0;
              ov_d    = 1'b1;
            end else begin
              state_d     = S_BUSY;
              ctrl_mult_d = is_mul;
              ctrl_div_d  = !is_mul;
            end
          end
        end
        S_BUSY: begin
          if (unit_ready) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            res_d   = unit_result;
            ov_d    = unit_exception;
          end else if (cnt_tc) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            res_d   = '0;
            ov_d    = 1'b1;
          end
        end
        S_DONE: begin
          if (x_advance) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      res_q       <= '0;
      ov_q        <= 1'b0;
      ready_q     <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      res_q       <= res_d;
      ov_q        <= ov_d;
      ready_q     <= ready_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
    end
  end

  assign ctrl_mult    = ctrl_mult_q;
  assign ctrl_div     = ctrl_div_q;
  assign unit_A       = unit_a_q;
  assign unit_B       = unit_b_q;
  assign muldiv_ready = ready_q;
  assign muldiv_res   = res_q;
  assign muldivov     = ov_q;
  assign busy         = (state_q == S_BUSY);

endmodule
